// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer
// Captures NUM_REGS data bytes on a start pulse. It then writes every byte enabled in the
// mask to the RTC bus driver, in ascending index order. An optional command write
// (CMD_ADDR/CMD_DATA) can follow the data writes. The sequence ends with a done pulse,
// or with the sticky error flag when the driver fails to acknowledge in time.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 one-cycle start pulse (ignored while busy)
//   i_datos_in              NUM_REGS bytes, byte i = i_datos_in[8i+7:8i]
//   i_reg_mask              per-byte write enable, sampled with start
//   i_cmd_en                append command write, sampled with start
//   o_wr_req/addr/data      write request to the bus driver
//   i_wr_ack                one-cycle transaction-complete pulse
//   o_busy                  sequence in progress
//   o_contador_datos        index of the byte being written
//   o_done                  one-cycle pulse on normal completion
//   o_error                 sticky timeout flag
module rtc_write_sequencer #(
    parameter int unsigned NUM_REGS   = 11,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [7:0]  CMD_ADDR   = 8'hF1,
    parameter logic [7:0]  CMD_DATA   = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [8*NUM_REGS-1:0] i_datos_in,
    input  logic [NUM_REGS-1:0]   i_reg_mask,
    input  logic                  i_cmd_en,
    output logic                  o_wr_req,
    output logic [7:0]            o_wr_addr,
    output logic [7:0]            o_wr_data,
    input  logic                  i_wr_ack,
    output logic                  o_busy,
    output logic [3:0]            o_contador_datos,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [3:0]    LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StScan, StReq, StGap, StCmd, StFin} state_e;

    state_e                r_state, w_state_next;
    logic [3:0]            r_idx, w_idx_next;
    logic [8*NUM_REGS-1:0] r_data, w_data_next;
    logic [NUM_REGS-1:0]   r_mask, w_mask_next;
    logic                  r_cmd_en, w_cmd_en_next;
    logic                  r_is_cmd, w_is_cmd_next;
    logic [7:0]            r_wr_addr, w_wr_addr_next;
    logic [7:0]            r_wr_data, w_wr_data_next;
    logic [TW-1:0]         r_tcnt, w_tcnt_next;
    logic [GW-1:0]         r_gcnt, w_gcnt_next;
    logic                  r_error, w_error_next;

    // The last GAP cycle already evaluates the next index. This keeps back-to-back enabled
    // bytes exactly GAP_CYCLES idle cycles apart.
    logic [3:0] w_sel_idx;
    logic       w_sel_en;
    logic [7:0] w_sel_byte;
    logic [7:0] w_sel_addr;

    assign w_sel_idx  = (r_state == StGap && r_idx != LAST_IDX) ? r_idx + 4'd1 : r_idx;
    assign w_sel_en   = r_mask[w_sel_idx];
    assign w_sel_byte = r_data[{w_sel_idx, 3'b000} +: 8];
    // Address table: 0..7 -> 21..28, 8..10 -> 41..43
    assign w_sel_addr = (w_sel_idx < 4'd8) ? 8'h21 + {4'd0, w_sel_idx}
                                           : 8'h39 + {4'd0, w_sel_idx};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_data    <= '0;
            r_mask    <= '0;
            r_cmd_en  <= 1'b0;
            r_is_cmd  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_tcnt    <= '0;
            r_gcnt    <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_data    <= w_data_next;
            r_mask    <= w_mask_next;
            r_cmd_en  <= w_cmd_en_next;
            r_is_cmd  <= w_is_cmd_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
            r_tcnt    <= w_tcnt_next;
            r_gcnt    <= w_gcnt_next;
            r_error   <= w_error_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_data_next    = r_data;
        w_mask_next    = r_mask;
        w_cmd_en_next  = r_cmd_en;
        w_is_cmd_next  = r_is_cmd;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_tcnt_next    = r_tcnt;
        w_gcnt_next    = r_gcnt;
        w_error_next   = r_error;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_data_next   = i_datos_in;
                    w_mask_next   = i_reg_mask;
                    w_cmd_en_next = i_cmd_en;
                    w_is_cmd_next = 1'b0;
                    w_error_next  = 1'b0;
                    w_idx_next    = '0;
                    w_state_next  = StScan;
                end
            end
            StScan: begin
                if (w_sel_en) begin
                    w_wr_addr_next = w_sel_addr;
                    w_wr_data_next = w_sel_byte;
                    w_tcnt_next    = '0;
                    w_state_next   = StReq;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = r_cmd_en ? StCmd : StFin;
                end else begin
                    w_idx_next = r_idx + 4'd1;
                end
            end
            StReq: begin
                if (i_wr_ack) begin
                    w_gcnt_next  = '0;
                    w_state_next = r_is_cmd ? StFin : StGap;
                end else if (r_tcnt == T_LAST) begin
                    w_error_next = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_tcnt_next = r_tcnt + 1'b1;
                end
            end
            StGap: begin
                if (r_gcnt != G_LAST) begin
                    w_gcnt_next = r_gcnt + 1'b1;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = r_cmd_en ? StCmd : StFin;
                end else begin
                    w_idx_next = w_sel_idx;
                    if (w_sel_en) begin
                        w_wr_addr_next = w_sel_addr;
                        w_wr_data_next = w_sel_byte;
                        w_tcnt_next    = '0;
                        w_state_next   = StReq;
                    end else begin
                        w_state_next = StScan;
                    end
                end
            end
            StCmd: begin
                w_wr_addr_next = CMD_ADDR;
                w_wr_data_next = CMD_DATA;
                w_is_cmd_next  = 1'b1;
                w_tcnt_next    = '0;
                w_state_next   = StReq;
            end
            StFin: begin
                // A start seen here is dropped on purpose; IDLE accepts the next one.
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        o_wr_req         = (r_state == StReq);
        o_busy           = (r_state != StIdle) && (r_state != StFin);
        o_done           = (r_state == StFin);
        o_wr_addr        = r_wr_addr;
        o_wr_data        = r_wr_data;
        o_contador_datos = r_idx;
        o_error          = r_error;
    end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
module tb_rtc_write_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, cmd_en, wr_ack;
    logic [87:0] datos_in;
    logic [10:0] reg_mask;
    logic        wr_req, busy, done, error;
    logic [7:0]  wr_addr, wr_data;
    logic [3:0]  contador;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_write_sequencer dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_datos_in       (datos_in),
        .i_reg_mask       (reg_mask),
        .i_cmd_en         (cmd_en),
        .o_wr_req         (wr_req),
        .o_wr_addr        (wr_addr),
        .o_wr_data        (wr_data),
        .i_wr_ack         (wr_ack),
        .o_busy           (busy),
        .o_contador_datos (contador),
        .o_done           (done),
        .o_error          (error)
    );

    logic [7:0] exp_addr [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                                  8'h41, 8'h42, 8'h43};

    // Transaction log, written only by the monitor
    logic [7:0] q_addr [$];
    logic [7:0] q_data [$];
    logic [3:0] q_cnt  [$];
    int         q_idle [$];
    int         q_hi   [$];
    int         done_cnt      = 0;
    int         done_busy_cnt = 0;
    int         unstable_cnt  = 0;
    int         withhold_req  = -1;

    initial begin : monitor
        logic       prev_req;
        logic [7:0] pa, pd;
        int         idle_run, hi_run;
        prev_req = 1'b0; pa = '0; pd = '0; idle_run = 0; hi_run = 0;
        forever begin
            @(posedge clk); #1;
            if (wr_req) begin
                if (!prev_req) begin
                    q_addr.push_back(wr_addr);
                    q_data.push_back(wr_data);
                    q_cnt.push_back(contador);
                    q_idle.push_back(idle_run);
                    hi_run = 0;
                end else if (wr_addr !== pa || wr_data !== pd) begin
                    unstable_cnt++;
                end
                hi_run++;
                idle_run = 0;
            end else begin
                if (prev_req) q_hi.push_back(hi_run);
                idle_run++;
            end
            if (done) begin
                done_cnt++;
                if (busy) done_busy_cnt++;
            end
            prev_req = wr_req; pa = wr_addr; pd = wr_data;
        end
    end

    // Bus driver: acks during the 4th cycle of each request unless that request is withheld
    initial begin : responder
        int hc, rc;
        hc = 0; rc = 0; wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wr_req) begin
                if (hc == 0) rc++;
                hc++;
            end else begin
                hc = 0;
            end
            wr_ack = wr_req && (hc == 4) && (rc - 1 != withhold_req);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [87:0] mk_data(input logic [7:0] base);
        logic [87:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) d[8*i +: 8] = base + 8'(i);
        return d;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic do_start(input logic [10:0] m, input logic c, input logic [87:0] d);
        reg_mask = m; cmd_en = c; datos_in = d; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && busy; i++) tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
        tick(2);
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        for (int i = 0; i < budget && q_addr.size() < target; i++) tick(1);
        checks++;
        if (q_addr.size() < target) begin
            errors++;
            $display("FAIL %s_wait: writes=%0d, required %0d", name, q_addr.size(), target);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; cmd_en = 1'b0; reg_mask = '0; datos_in = '0;
        tick(3);
        checks += 7;
        if (wr_req !== 1'b0) begin errors++; $display("FAIL rst_wr_req: got %b want 0", wr_req); end
        if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", wr_addr); end
        if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", wr_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (contador !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", contador); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_full_sequence;
        int b, bd;
        b = q_addr.size(); bd = done_cnt;
        do_start(11'h7FF, 1'b0, mk_data(8'h01));
        wait_idle(500, "full");
        checks++;
        if (q_addr.size() - b != 11) begin
            errors++; $display("FAIL full_count: got %0d writes want 11", q_addr.size() - b);
        end
        for (int k = 0; k < 11; k++) begin
            checks += 2;
            if (q_addr[b+k] !== exp_addr[k]) begin
                errors++; $display("FAIL full_addr%0d: got %h want %h", k, q_addr[b+k], exp_addr[k]);
            end
            if (q_data[b+k] !== 8'(k + 1)) begin
                errors++; $display("FAIL full_data%0d: got %h want %h", k, q_data[b+k], 8'(k + 1));
            end
        end
        for (int k = 1; k < 11; k++) begin
            checks++;
            if (q_idle[b+k] != 4) begin
                errors++; $display("FAIL full_gap%0d: got %0d idle cycles want 4", k, q_idle[b+k]);
            end
        end
        checks += 4;
        if (done_cnt - bd != 1) begin
            errors++; $display("FAIL full_done: got %0d pulses want 1", done_cnt - bd);
        end
        if (done_busy_cnt != 0) begin
            errors++; $display("FAIL full_done_busy: got %0d want 0", done_busy_cnt);
        end
        if (unstable_cnt != 0) begin
            errors++; $display("FAIL full_stable: got %0d changes want 0", unstable_cnt);
        end
        if (error !== 1'b0) begin errors++; $display("FAIL full_error: got %b want 0", error); end
    endtask

    task automatic test_sparse_cmd;
        int b, bd;
        logic [7:0] ea [4];
        logic [7:0] ed [4];
        ea = '{8'h21, 8'h23, 8'h43, 8'hF1};
        ed = '{8'hA0, 8'hA2, 8'hAA, 8'h00};
        b = q_addr.size(); bd = done_cnt;
        do_start(11'b10000000101, 1'b1, mk_data(8'hA0));
        wait_idle(500, "sparse");
        checks++;
        if (q_addr.size() - b != 4) begin
            errors++; $display("FAIL sparse_count: got %0d writes want 4", q_addr.size() - b);
        end
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (q_addr[b+k] !== ea[k]) begin
                errors++; $display("FAIL sparse_addr%0d: got %h want %h", k, q_addr[b+k], ea[k]);
            end
            if (q_data[b+k] !== ed[k]) begin
                errors++; $display("FAIL sparse_data%0d: got %h want %h", k, q_data[b+k], ed[k]);
            end
        end
        checks += 3;
        if (q_cnt[b] !== 4'd0) begin
            errors++; $display("FAIL sparse_cnt0: got %0d want 0", q_cnt[b]);
        end
        if (q_cnt[b+2] !== 4'd10) begin
            errors++; $display("FAIL sparse_cnt10: got %0d want 10", q_cnt[b+2]);
        end
        if (done_cnt - bd != 1) begin
            errors++; $display("FAIL sparse_done: got %0d pulses want 1", done_cnt - bd);
        end
    endtask

    task automatic test_timeout;
        int b, bh, bd;
        b = q_addr.size(); bh = q_hi.size(); bd = done_cnt;
        withhold_req = b + 1;
        do_start(11'h7FF, 1'b0, mk_data(8'h10));
        wait_idle(700, "tmo");
        checks += 6;
        if (q_addr.size() - b != 2) begin
            errors++; $display("FAIL tmo_count: got %0d writes want 2", q_addr.size() - b);
        end
        if (q_hi[bh+1] != 255) begin
            errors++; $display("FAIL tmo_len: got %0d req cycles want 255", q_hi[bh+1]);
        end
        if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b want 1", error); end
        if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
        if (wr_req !== 1'b0) begin errors++; $display("FAIL tmo_req: got %b want 0", wr_req); end
        if (done_cnt != bd) begin
            errors++; $display("FAIL tmo_done: got %0d pulses want 0", done_cnt - bd);
        end
        withhold_req = -1;
        b = q_addr.size(); bd = done_cnt;
        do_start(11'h7FF, 1'b0, mk_data(8'h30));
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", error); end
        wait_idle(500, "tmo_rerun");
        checks += 2;
        if (q_addr.size() - b != 11) begin
            errors++; $display("FAIL tmo_rerun_count: got %0d writes want 11", q_addr.size() - b);
        end
        if (done_cnt - bd != 1) begin
            errors++; $display("FAIL tmo_rerun_done: got %0d pulses want 1", done_cnt - bd);
        end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (q_data[b+k] !== 8'(8'h30 + k)) begin
                errors++;
                $display("FAIL tmo_rerun_data%0d: got %h want %h", k, q_data[b+k], 8'(8'h30 + k));
            end
        end
    endtask

    task automatic test_start_while_busy;
        int b, bd;
        b = q_addr.size(); bd = done_cnt;
        do_start(11'h7FF, 1'b0, mk_data(8'h50));
        wait_writes(b + 5, 300, "busy");
        do_start(11'h001, 1'b1, mk_data(8'hE0));
        wait_idle(500, "busy");
        checks += 2;
        if (q_addr.size() - b != 11) begin
            errors++; $display("FAIL busy_count: got %0d writes want 11", q_addr.size() - b);
        end
        if (done_cnt - bd != 1) begin
            errors++; $display("FAIL busy_done: got %0d pulses want 1", done_cnt - bd);
        end
        for (int k = 0; k < 11; k++) begin
            checks += 2;
            if (q_addr[b+k] !== exp_addr[k]) begin
                errors++; $display("FAIL busy_addr%0d: got %h want %h", k, q_addr[b+k], exp_addr[k]);
            end
            if (q_data[b+k] !== 8'(8'h50 + k)) begin
                errors++;
                $display("FAIL busy_data%0d: got %h want %h", k, q_data[b+k], 8'(8'h50 + k));
            end
        end
    endtask

    task automatic test_reset_mid;
        int b, bd;
        b = q_addr.size(); bd = done_cnt;
        do_start(11'h7FF, 1'b0, mk_data(8'h70));
        wait_writes(b + 3, 200, "rmid");
        reset = 1'b1;
        tick(1);
        checks += 7;
        if (wr_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", wr_req); end
        if (wr_addr !== 8'h00) begin errors++; $display("FAIL rmid_addr: got %h want 00", wr_addr); end
        if (wr_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", wr_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (contador !== 4'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", contador); end
        if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL rmid_error: got %b want 0", error); end
        reset = 1'b0;
        tick(40);
        checks += 2;
        if (q_addr.size() - b != 3) begin
            errors++; $display("FAIL rmid_count: got %0d writes want 3", q_addr.size() - b);
        end
        if (done_cnt != bd) begin
            errors++; $display("FAIL rmid_nodone: got %0d pulses want 0", done_cnt - bd);
        end
    endtask

    task automatic test_empty_mask;
        int b, n;
        logic seen;
        b = q_addr.size(); seen = 1'b0; n = 0;
        do_start(11'h000, 1'b0, mk_data(8'h90));
        // done must appear within 13 cycles of the start edge (one already elapsed)
        for (int i = 1; i <= 12 && !seen; i++) begin
            tick(1);
            n = i;
            if (done) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL empty_done: got no done in %0d cycles, want done", n + 1);
        end
        tick(3);
        if (q_addr.size() != b) begin
            errors++; $display("FAIL empty_noreq: got %0d writes want 0", q_addr.size() - b);
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_sparse_cmd();
        test_timeout();
        test_start_while_busy();
        test_reset_mid();
        test_empty_mask();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_write_sequencer.md
Name: rtc_write_sequencer

Overview:
- Write-direction counterpart of the 11-register RTC read capture bank.
- Snapshots 11 byte values (time, date and timer fields) on a start pulse, then issues one bus write per enabled register to the RTC bus controller, in fixed order.
- Optionally finishes with a command write, then reports done or timeout error.
- Sits between the user time-setting logic and the RTC bus driver.

Parameters:
- NUM_REGS, 11, number of data registers; address table below is fixed for 11.
- GAP_CYCLES, 4, idle clk cycles between consecutive bus transactions (min 1).
- TIMEOUT, 255, max clk cycles wr_req may wait for wr_ack before abort.
- CMD_ADDR, 8'hF1, address of trailing command write.
- CMD_DATA, 8'h00, data of trailing command write.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only when busy=0
- datos_in  in  88  11 bytes; byte i = datos_in[8i+7:8i]
- reg_mask  in  11  bit i=1 enables write of byte i; sampled with start
- cmd_en  in  1  1 = append command write; sampled with start
- wr_req  out  1  transaction request to bus driver
- wr_addr  out  8  write address, valid while wr_req=1
- wr_data  out  8  write data, valid while wr_req=1
- wr_ack  in  1  one-cycle pulse from bus driver: transaction complete
- busy  out  1  sequence in progress
- contador_datos  out  4  index of byte currently being written (0-10)
- done  out  1  one-cycle pulse at normal completion
- error  out  1  sticky timeout flag; cleared by next accepted start or reset

Behaviour:
- Address table, index 0..10: 21,22,23,24,25,26,27,28,41,42,43 (hex).
- Reset values: wr_req=0, wr_addr=0, wr_data=0, busy=0, contador_datos=0, done=0, error=0, state=IDLE. Reset mid-sequence aborts immediately. No write is issued after the reset cycle.
- IDLE:
  - On start=1, latch datos_in, reg_mask and cmd_en into internal registers.
  - Clear error, set busy=1, set idx=0, go to SCAN.
  - Latency from start to first wr_req is at most 12 cycles (scan) plus 1.
- SCAN: one cycle per index.
  - If mask[idx]=1: load wr_addr/wr_data from the table and the latched byte, go to REQ.
  - Otherwise idx++.
  - When idx passes 10: go to CMD if cmd_en, else FIN.
  - contador_datos follows idx.
- REQ:
  - wr_req=1; wr_addr and wr_data held stable. Timeout counter starts at 0.
  - On wr_ack=1: wr_req=0 on the next edge, go to GAP.
  - If the counter reaches TIMEOUT with no ack: wr_req=0, error=1, busy=0, go to IDLE. done is not pulsed.
  - wr_ack is ignored in every other state.
- GAP: wait GAP_CYCLES cycles, then idx++ and return to SCAN. If the data writes are exhausted, go to CMD or FIN instead.
- CMD: wr_addr=CMD_ADDR, wr_data=CMD_DATA, then REQ/ack/timeout rules as above. After ack, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- Edge cases:
  - reg_mask=0 and cmd_en=0: done pulses; no wr_req is ever asserted.
  - start while busy=1 is ignored; latched data is unaffected.
  - datos_in changes after start do not affect the sequence.
  - start in the same cycle as done (FIN) is ignored. It is accepted the next cycle in IDLE.
  - wr_ack in the same cycle wr_req first rises counts as a valid ack.
- Width rules:
  - idx is 4 bits and never exceeds 10 while addressing.
  - The timeout counter saturates and is sized ceil(log2(TIMEOUT+1)).

Test Plan:
1. Reset, start with reg_mask=11'h7FF, cmd_en=0, bytes = index+1, ack 3 cycles after each req.
   - Required: 11 writes, addrs 21..28,41,42,43 with data 01..0B.
   - Exactly 4 idle cycles between req deassert and next req.
   - done pulses once; busy falls with done.
2. reg_mask=11'b10000000101, cmd_en=1.
   - Required: writes only to 21(d0), 23(d2), 43(d10), then F1/00; done=1; contador_datos=10 during the 43 write.
3. Ack withheld on the second write.
   - Required: wr_req drops after 255 cycles, error=1, busy=0, no done.
   - Next start clears error and runs a full sequence.
4. Second start pulse during write 5 plus datos_in changed mid-sequence.
   - Required: sequence unchanged, original data written, single done.
5. Assert reset while wr_req=1 on write 3.
   - Required: next cycle all outputs are at reset values; no further writes occur.
6. reg_mask=0, cmd_en=0.
   - Required: done within 13 cycles of start; wr_req never asserted.
